// File: rtl/seg_frame_sched.sv
// seg_frame_sched
//    Shares one serial seven-segment shift chain between two 64-bit frame
//    requesters (score panel = source 0, banner panel = source 1).
//    Requests are arbitrated round-robin. The granted frame is captured
//    into a shift register and sent MSB-first. seg_dt changes on the
//    falling side of seg_clk and is sampled by the chain on the rising
//    side.
//
//    Parameter:
//       DIV      clk cycles per seg_clk half-period (1..255)
//    Ports:
//       clk, rst         system clock, asynchronous active-high reset
//       req0, frame0     score request (level) and frame
//       req1, frame1     banner request (level) and frame
//       grant0, grant1   one-cycle capture pulses
//       busy             grant cycle through done cycle
//       done             one-cycle pulse after the last bit's high phase
//       seg_clk, seg_dt  shift clock and serial data to the chain
//       seg_clr, seg_en  active-low chain clear, chain output enable
module seg_frame_sched #(
   parameter int DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [63:0] frame0,
   input  logic        req1,
   input  logic [63:0] frame1,
   output logic        grant0,
   output logic        grant1,
   output logic        busy,
   output logic        done,
   output logic        seg_clk,
   output logic        seg_clr,
   output logic        seg_dt,
   output logic        seg_en
);

   localparam int PW = $clog2(DIV + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [63:0]   shreg;
   logic [5:0]    bit_idx;
   logic [PW-1:0] phase;
   logic          last_grant;

   logic arb_en, start, pick0, pick1, ph_end, last_bit;
   logic grant0_next, grant1_next, busy_next, done_next;
   logic seg_clk_next, seg_dt_next;

   // Arbitration is open in IDLE and also in DONE, so a request already
   // waiting when a transfer finishes is granted without passing IDLE.
   assign arb_en   = (state == IDLE) || (state == DONE);
   assign start    = arb_en && (req0 || req1);
   // On a tie the source that was not granted last wins.
   assign pick0    = req0 && (!req1 || last_grant);
   assign pick1    = req1 && (!req0 || !last_grant);
   assign ph_end   = (phase == PH_LAST);
   assign last_bit = (bit_idx == 6'd0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOW;
         LOW:     if (ph_end) state_next = HIGH;
         HIGH:    if (ph_end) state_next = last_bit ? DONE : LOW;
         DONE:    state_next = start ? LOW : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      grant0_next  = 1'b0;
      grant1_next  = 1'b0;
      done_next    = 1'b0;
      busy_next    = busy;
      seg_clk_next = seg_clk;
      seg_dt_next  = seg_dt;
      case (state)
         IDLE, DONE: begin
            seg_clk_next = 1'b0;
            if (start) begin
               grant0_next = pick0;
               grant1_next = pick1;
               busy_next   = 1'b1;
               seg_dt_next = pick0 ? frame0[63] : frame1[63];
            end else begin
               busy_next   = 1'b0;
               seg_dt_next = 1'b0;
            end
         end
         LOW: begin
            if (ph_end) seg_clk_next = 1'b1;
         end
         HIGH: begin
            if (ph_end) begin
               seg_clk_next = 1'b0;
               if (last_bit) begin
                  done_next   = 1'b1;
                  seg_dt_next = 1'b0;
               end else begin
                  // Next bit appears on the same edge that drops seg_clk.
                  seg_dt_next = shreg[62];
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= 64'd0;
         bit_idx    <= 6'd0;
         phase      <= '0;
         last_grant <= 1'b1;
         grant0     <= 1'b0;
         grant1     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         seg_clk    <= 1'b0;
         seg_dt     <= 1'b0;
      end else begin
         grant0  <= grant0_next;
         grant1  <= grant1_next;
         busy    <= busy_next;
         done    <= done_next;
         seg_clk <= seg_clk_next;
         seg_dt  <= seg_dt_next;
         if (start) begin
            shreg      <= pick0 ? frame0 : frame1;
            bit_idx    <= 6'd63;
            phase      <= '0;
            last_grant <= pick1;
         end else if (state == LOW || state == HIGH) begin
            if (ph_end) begin
               phase <= '0;
               if (state == HIGH && !last_bit) begin
                  shreg   <= shreg << 1;
                  bit_idx <= bit_idx - 6'd1;
               end
            end else begin
               phase <= phase + 1'b1;
            end
         end
      end
   end

   // Chain clear/enable release on the first edge after reset and stay set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_clr <= 1'b0;
         seg_en  <= 1'b0;
      end else begin
         seg_clr <= 1'b1;
         seg_en  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_frame_sched.sv
// Testbench for seg_frame_sched: one instance with DIV=2 (main tests) and
// one with DIV=1 (fastest-divider boundary). Expected grants and frames
// are queued when stimulus is driven; monitors pop and compare them when
// the design reports grant/done.
module tb_seg_frame_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [63:0] frame0 = 64'd0, frame1 = 64'd0;
   logic        grant0, grant1, busy, done, seg_clk, seg_clr, seg_dt, seg_en;

   logic        req0_b = 1'b0, req1_b = 1'b0;
   logic [63:0] frame0_b = 64'd0, frame1_b = 64'd0;
   logic        grant0_b, grant1_b, busy_b, done_b, seg_clk_b, seg_clr_b, seg_dt_b, seg_en_b;

   int checks = 0;
   int failures = 0;

   logic        exp_grant[$];
   logic [63:0] exp_frame[$];
   logic [63:0] exp_frame_b[$];

   always #5 clk = ~clk;

   seg_frame_sched #(.DIV(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .frame0(frame0), .req1(req1), .frame1(frame1),
      .grant0(grant0), .grant1(grant1), .busy(busy), .done(done),
      .seg_clk(seg_clk), .seg_clr(seg_clr), .seg_dt(seg_dt), .seg_en(seg_en)
   );

   seg_frame_sched #(.DIV(1)) dut_b (
      .clk(clk), .rst(rst),
      .req0(req0_b), .frame0(frame0_b), .req1(req1_b), .frame1(frame1_b),
      .grant0(grant0_b), .grant1(grant1_b), .busy(busy_b), .done(done_b),
      .seg_clk(seg_clk_b), .seg_clr(seg_clr_b), .seg_dt(seg_dt_b), .seg_en(seg_en_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic wait_grant(input string tag);
      int got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (grant0 || grant1) begin
            got = 1;
            break;
         end
      end
      check(tag, got, 1);
   endtask

   task automatic wait_done(input string tag);
      int got = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      check(tag, got, 1);
   endtask

   // Monitor for the DIV=2 instance
   initial begin
      logic [63:0] cap = 64'd0;
      int nbits = 0;
      int busy_len = 0;
      logic prev_clk = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            nbits = 0; busy_len = 0; prev_clk = 1'b0; cap = 64'd0;
         end else begin
            if (seg_clk && !prev_clk) begin
               cap = {cap[62:0], seg_dt};
               nbits++;
            end
            prev_clk = seg_clk;
            if (grant0 || grant1) begin
               check("grant_onehot", grant0 & grant1, 1'b0);
               if (exp_grant.size() == 0) check("grant_unexpected", 1, 0);
               else check("grant_src", grant1, exp_grant.pop_front());
               nbits = 0; cap = 64'd0;
            end
            if (busy) busy_len++;
            if (done) begin
               check("done_bits", nbits, 64);
               if (exp_frame.size() == 0) check("done_unexpected", 1, 0);
               else check("frame", cap, exp_frame.pop_front());
               check("busy_len", busy_len, 257);
               busy_len = 0;
            end
         end
      end
   end

   // Monitor for the DIV=1 instance
   initial begin
      logic [63:0] cap = 64'd0;
      int nbits = 0;
      int busy_len = 0;
      int bad_toggle = 0;
      logic prev_clk = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            nbits = 0; busy_len = 0; bad_toggle = 0; prev_clk = 1'b0; cap = 64'd0;
         end else begin
            if (seg_clk_b && !prev_clk) begin
               cap = {cap[62:0], seg_dt_b};
               nbits++;
            end
            if (busy_b && !grant0_b && !done_b && (seg_clk_b == prev_clk)) bad_toggle++;
            prev_clk = seg_clk_b;
            if (grant0_b || grant1_b) begin
               nbits = 0; cap = 64'd0; bad_toggle = 0;
            end
            if (busy_b) busy_len++;
            if (done_b) begin
               check("div1_bits", nbits, 64);
               if (exp_frame_b.size() == 0) check("div1_unexpected", 1, 0);
               else check("div1_frame", cap, exp_frame_b.pop_front());
               check("div1_busy_len", busy_len, 129);
               check("div1_toggle", bad_toggle, 0);
               busy_len = 0;
            end
         end
      end
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int grants, dones, cyc, done_cyc, early, got;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {grant0, grant1, busy, done, seg_clk, seg_clr, seg_dt, seg_en}, 8'h00);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("clr_before_edge", {seg_clr, seg_en}, 2'b00);
      @(posedge clk); #1;
      check("clr_after_edge", {seg_clr, seg_en, busy}, 3'b110);

      // Single score frame with grant latency
      frame0 = 64'h92C6C088_86000000;
      exp_grant.push_back(1'b0);
      exp_frame.push_back(64'h92C6C088_86000000);
      req0 = 1'b1;
      @(posedge clk); #1;
      check("grant_latency", {grant0, busy, seg_dt}, 3'b111);
      req0 = 1'b0;
      wait_done("single_done");

      // Tie then alternation, starting from reset
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      frame0 = 64'h01234567_89ABCDEF;
      frame1 = 64'hFEDCBA98_76543210;
      exp_grant.push_back(1'b0); exp_frame.push_back(64'h01234567_89ABCDEF);
      exp_grant.push_back(1'b1); exp_frame.push_back(64'hFEDCBA98_76543210);
      exp_grant.push_back(1'b0); exp_frame.push_back(64'h01234567_89ABCDEF);
      req0 = 1'b1; req1 = 1'b1;
      grants = 0; dones = 0; cyc = 0; done_cyc = 0;
      for (int i = 0; i < 1200 && dones < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (grant0 || grant1) begin
            grants++;
            if (grants > 1) check("tie_gap", cyc - done_cyc, 1);
            if (grants == 3) begin
               req0 = 1'b0; req1 = 1'b0;
            end
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end
      check("tie_dones", dones, 3);

      // Request during a transfer stays pending until DONE
      @(posedge clk); #1;
      frame0 = 64'hA5A50F0F_3C3CFF00;
      exp_grant.push_back(1'b0); exp_frame.push_back(64'hA5A50F0F_3C3CFF00);
      req0 = 1'b1;
      wait_grant("pend_grant0");
      req0 = 1'b0;
      repeat (172) @(negedge clk);      // now inside bit 20
      frame1 = 64'h80000000_00000001;
      exp_grant.push_back(1'b1); exp_frame.push_back(64'h80000000_00000001);
      req1 = 1'b1;
      early = 0; got = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (grant1) early++;
         if (done) begin
            got = 1;
            break;
         end
      end
      check("pend_done", got, 1);
      check("pend_no_early_grant", early, 0);
      @(negedge clk);
      check("pend_grant1_after_done", grant1, 1'b1);
      req1 = 1'b0;
      wait_done("pend_done1");

      // Frame change right after grant does not affect the stream
      @(posedge clk); #1;
      frame0 = 64'hDEADBEEF_CAFEF00D;
      exp_grant.push_back(1'b0); exp_frame.push_back(64'hDEADBEEF_CAFEF00D);
      req0 = 1'b1;
      wait_grant("chg_grant");
      req0 = 1'b0;
      @(posedge clk); #1 frame0 = 64'd0;
      wait_done("chg_done");

      // Reset in the middle of a transfer, pending req0 re-granted
      @(posedge clk); #1;
      frame0 = 64'h13579BDF_2468ACE0;
      exp_grant.push_back(1'b0); exp_frame.push_back(64'h13579BDF_2468ACE0);
      req0 = 1'b1;
      wait_grant("rst_grant");
      repeat (92) @(negedge clk);       // now inside bit 40
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("rst_async_outs", {grant0, grant1, busy, done, seg_clk, seg_clr, seg_dt, seg_en}, 8'h00);
      exp_grant.push_back(1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_clr_held", {seg_clr, seg_en, done}, 3'b000);
      @(posedge clk); #1;
      check("rst_clr_release", {seg_clr, seg_en}, 2'b11);
      check("rst_regrant", grant0, 1'b1);
      req0 = 1'b0;
      wait_done("rst_done");

      // DIV=1 boundary on the second instance
      @(posedge clk); #1;
      frame0_b = 64'hC3C35A5A_0000FFFF;
      exp_frame_b.push_back(64'hC3C35A5A_0000FFFF);
      req0_b = 1'b1;
      @(posedge clk); #1;
      check("div1_grant", {grant0_b, grant1_b}, 2'b10);
      req0_b = 1'b0;
      got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_b) begin
            got = 1;
            break;
         end
      end
      check("div1_done", got, 1);

      repeat (3) @(posedge clk);
      check("grant_queue_empty", exp_grant.size(), 0);
      check("frame_queue_empty", exp_frame.size() + exp_frame_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_frame_sched.md
# seg_frame_sched

Scheduler for the board's serial seven-segment chain: shares one shift chain between two 64-bit frame requesters, the score panel and the banner/message panel. Each granted frame is serialized MSB-first onto seg_clk/seg_dt. Requests are arbitrated round-robin, so neither source starves. It sits between the frame builders (score decode, banner text) and the SWORD segment pins, and replaces a free-running serializer.

## Interface

- DIV, default 2: clk cycles per seg_clk half-period; legal range 1..255.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  score requester; level, held high until grant0.
- frame0  in  64  score frame; segment byte for digit 7 in [63:56], down to digit 0 in [7:0]; stable while req0 is high.
- req1  in  1  banner requester; level, held high until grant1.
- frame1  in  64  banner frame, same layout as frame0.
- grant0  out  1  one-cycle pulse: frame0 captured.
- grant1  out  1  one-cycle pulse: frame1 captured.
- busy  out  1  high from the grant cycle through the done cycle.
- done  out  1  one-cycle pulse after the last bit's high phase.
- seg_clk  out  1  shift clock to the chain; idles low; data shifts on its rising edge.
- seg_clr  out  1  active-low chain clear.
- seg_dt  out  1  serial data.
- seg_en  out  1  chain output enable.

## Operation

- States are IDLE, LOW, HIGH and DONE. All outputs are registered.
- **IDLE:** seg_clk=0. If any req is high, arbitrate:
  - Only one req high: grant that one.
  - Both high: grant the source not granted last; last_grant resets to 1, so req0 wins the first tie.
  - The granted frame is loaded into the 64-bit shift register at that edge.
  - The next state is LOW with the grant pulse, bit index 63, busy=1 and seg_dt=frame[63].
- **LOW:** seg_clk=0 and seg_dt holds the current bit, for DIV cycles. Then go to HIGH.
- **HIGH:** seg_clk=1 for DIV cycles, with seg_dt unchanged.
  - At the end, if bits remain: shift left, present the next bit in seg_dt at the same edge that returns seg_clk to 0, and go to LOW.
  - After bit 0: go to DONE.
- **DONE:** one cycle with seg_clk=0, seg_dt=0, done=1 and busy=1. Then go to IDLE.
  - A new grant can be issued at the edge leaving DONE only if a req is already sampled high in DONE. Otherwise the next grant comes from IDLE.
- Requests arriving while busy stay pending, because req is a level signal. They are arbitrated at the DONE→IDLE decision point.
- A req that drops before its grant is forgotten.
- Frames are captured only at grant; later changes to frame0/frame1 do not affect a transfer in progress.
- The phase counter is ceil(log2(DIV+1)) bits and the bit index is 6 bits. Neither wraps inside a transfer; both reload on every grant.
- seg_clr and seg_en are 0 in reset and 1 from the first clk edge after rst falls. They stay 1 thereafter.

## Timing

- Reset values: state=IDLE, last_grant=1, shift register=0. Outputs grant0, grant1, busy, done, seg_clk, seg_dt, seg_clr and seg_en are all 0.
- Grant latency: req high in an IDLE cycle gives grant at the next edge. That grant cycle is the first LOW cycle of bit 63.
- Transfer length: busy stays high for 128·DIV + 1 cycles (64 bits × 2·DIV, plus DONE).
- seg_clk has exactly 64 rising edges per transfer. Each rising edge sits DIV cycles after its seg_dt change, so setup is DIV cycles and hold is DIV cycles.
- Back-to-back transfers: if req is high during DONE, the next grant comes in the cycle after DONE. This gives a 1-cycle seg_clk low gap beyond the normal LOW phase.
- Reset mid-transfer:
  - Immediate abort, with all outputs at their reset values.
  - No done pulse.
  - The partially shifted chain content is undefined until seg_clr is released and a full frame is resent.
- Simultaneous events:
  - A request in the DONE cycle counts as pending, not lost.
  - grant0 and grant1 are never high together.

## Test plan

- **Single score frame:** DIV=2, req0=1, frame0=64'h92C6C088_86000000. Required response:
  - grant0 pulses one cycle after req0.
  - seg_dt on the 64 seg_clk rising edges reproduces frame0 MSB-first.
  - busy lasts 257 cycles, and done pulses once in its last cycle.
- **Tie then alternation:** after reset, req0 and req1 are both held high for three transfers. Grant order must be 0, 1, 0. Between dones the gap from done to the next grant is exactly 1 cycle.
- **Request during a transfer:** raise req1 during bit 20 of a req0 transfer. There is no grant1 until after done. grant1 follows in the cycle after DONE, and the frame0 serial stream is unaltered.
- **Frame change after grant:** change frame0 to 64'h0 one cycle after grant0. The serial stream still equals the originally captured frame.
- **Reset mid-transfer:** assert rst at bit 40. All outputs go to 0 immediately and there is no done pulse. After release, seg_clr and seg_en rise at the next edge. A pending req0 is re-granted with the full 64 bits.
- **DIV=1 boundary:** seg_clk toggles every cycle, busy lasts 129 cycles, and the bits are correct.
